// File: rtl/bias_grad_accum.sv
// -----------------------------------------------------------------------------
// bias_grad_accum
//
// Streaming FP16 bias-gradient reducer for the convolution backward pass.
// It accepts a WIDTH x HEIGHT map of FP16 output-gradient elements, one per
// cycle, and sums them in arrival order ((0+e0)+e1)+... with a single reused
// floatAdd instance. The finished sum is held on grad_out until it is taken.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a reduction (sampled in IDLE only)
//   in_valid   in   in_data holds a gradient element
//   in_ready   out  element accepted this cycle (decode of state only)
//   in_data    in   [0:15] FP16 element, bit 0 = sign
//   grad_valid out  grad_out holds the finished sum (registered)
//   grad_ready in   consumer takes grad_out
//   grad_out   out  [0:15] FP16 bias gradient (registered)
//   busy       out  state is not IDLE
//   state_dbg  out  raw FSM state (0 IDLE, 1 ACCUM, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends combinationally on valid; once grad_valid is
// raised it and grad_out stay stable until the grad_ready transfer.
//
// Optional feature macro: BIAS_GRAD_NEG_EN
//   defined   -> the sign of grad_out is inverted when the result is
//                registered, so the block emits -sum. The internal
//                accumulator is never negated.
//   undefined -> grad_out is the plain sum.
// -----------------------------------------------------------------------------

// FP16 adder (IEEE binary16, round-to-nearest-even, subnormals supported).
// Bit 0 of each operand is the sign, bits 1:5 the exponent, 6:15 the fraction.
module floatAdd (
  input  logic [0:15] a,
  input  logic [0:15] b,
  output logic [0:15] y
);
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        a_is_l;
  logic [0:15] op_l, op_s;
  logic        s_l, s_s, op_sub;
  logic [4:0]  e_l, e_s, diff;
  logic [10:0] m_l, m_s;
  logic [13:0] al_l, al_s;
  logic [14:0] sum;
  logic [13:0] norm;
  logic [5:0]  exp_n, exp_r;
  logic        rup;
  logic [11:0] rnd;
  logic [4:0]  exp_f;
  logic [9:0]  frac_f;

  assign a_nan = (a[1:5] == 5'h1f) && (a[6:15] != 10'h0);
  assign b_nan = (b[1:5] == 5'h1f) && (b[6:15] != 10'h0);
  assign a_inf = (a[1:5] == 5'h1f) && (a[6:15] == 10'h0);
  assign b_inf = (b[1:5] == 5'h1f) && (b[6:15] == 10'h0);

  // Magnitude ordering keeps the subtraction result non-negative.
  assign a_is_l = (a[1:15] >= b[1:15]);
  assign op_l   = a_is_l ? a : b;
  assign op_s   = a_is_l ? b : a;

  always_comb begin
    s_l    = op_l[0];
    s_s    = op_s[0];
    op_sub = s_l ^ s_s;
    // Subnormals use exponent 1 with no hidden bit.
    e_l    = (op_l[1:5] == 5'h0) ? 5'd1 : op_l[1:5];
    e_s    = (op_s[1:5] == 5'h0) ? 5'd1 : op_s[1:5];
    m_l    = {(op_l[1:5] != 5'h0), op_l[6:15]};
    m_s    = {(op_s[1:5] != 5'h0), op_s[6:15]};
    diff   = e_l - e_s;

    // Three extra bits: guard, round, sticky. Bits shifted out are folded
    // into bit 0 so the sticky information survives any shift distance.
    al_l = {m_l, 3'b000};
    al_s = {m_s, 3'b000};
    for (int i = 0; i < 16; i++) begin
      if (i < int'(diff)) begin
        al_s = {1'b0, al_s[13:2], al_s[1] | al_s[0]};
      end
    end

    sum   = op_sub ? ({1'b0, al_l} - {1'b0, al_s}) : ({1'b0, al_l} + {1'b0, al_s});
    exp_n = {1'b0, e_l};

    if (sum[14]) begin
      norm  = {sum[14:2], sum[1] | sum[0]};
      exp_n = exp_n + 6'd1;
    end else begin
      norm = sum[13:0];
      // Left-normalise but never below exponent 1 (gradual underflow).
      for (int i = 0; i < 14; i++) begin
        if (!norm[13] && (exp_n > 6'd1)) begin
          norm  = {norm[12:0], 1'b0};
          exp_n = exp_n - 6'd1;
        end
      end
    end

    rup   = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd   = {1'b0, norm[13:3]} + {11'h0, rup};
    exp_r = rnd[11] ? (exp_n + 6'd1) : exp_n;
    frac_f = rnd[11] ? rnd[10:1] : rnd[9:0];
    exp_f  = (rnd[11] | rnd[10]) ? exp_r[4:0] : 5'h0;

    if (a_nan || b_nan || (a_inf && b_inf && (a[0] != b[0]))) begin
      y = 16'h7e00;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (op_sub && (sum == 15'h0)) begin
      y = 16'h0000;                       // exact cancellation gives +0
    end else if ((rnd[11] | rnd[10]) && (exp_r >= 6'd31)) begin
      y = {s_l, 5'h1f, 10'h0};            // overflow to infinity
    end else begin
      y = {s_l, exp_f, frac_f};
    end
  end
endmodule

module bias_grad_accum #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:15] in_data,
  output logic        grad_valid,
  input  logic        grad_ready,
  output logic [0:15] grad_out,
  output logic        busy,
  output logic [1:0]  state_dbg
);
  localparam int N     = WIDTH * HEIGHT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [0:15]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grad_valid_q, grad_valid_d;
  logic [0:15]      grad_out_q, grad_out_d;
  logic [0:15]      sum;
  logic [0:15]      result;

  floatAdd u_add (
    .a (acc_q),
    .b (in_data),
    .y (sum)
  );

`ifdef BIAS_GRAD_NEG_EN
  assign result = {~sum[0], sum[1:15]};
`else
  assign result = sum;
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    grad_valid_d = grad_valid_q;
    grad_out_d   = grad_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 16'h0000;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // in_ready is 1 throughout ACCUM, so in_valid alone marks a transfer.
        if (in_valid) begin
          acc_d = sum;
          if (cnt_q == CNT_LAST) begin
            // Hold cnt on the last element so it never wraps.
            state_d      = S_DONE;
            grad_valid_d = 1'b1;
            grad_out_d   = result;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here; the block returns to
        // IDLE first even if start coincides with grad_ready.
        if (grad_ready) begin
          state_d      = S_IDLE;
          grad_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= 16'h0000;
      cnt_q        <= '0;
      grad_valid_q <= 1'b0;
      grad_out_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      grad_valid_q <= grad_valid_d;
      grad_out_q   <= grad_out_d;
    end
  end

  assign in_ready   = (state_q == S_ACCUM);
  assign busy       = (state_q != S_IDLE);
  assign grad_valid = grad_valid_q;
  assign grad_out   = grad_out_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_bias_grad_accum.sv
// Testbench for bias_grad_accum with a 2x2 map (N = 4).
module tb_bias_grad_accum;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] in_data;
  logic        grad_valid;
  logic        grad_ready;
  logic [0:15] grad_out;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  bias_grad_accum #(.WIDTH(2), .HEIGHT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_out   (grad_out),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [15:0] expv(input logic [15:0] v);
`ifdef BIAS_GRAD_NEG_EN
    return v ^ 16'h8000;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("in_ready_after_start", {15'h0, in_ready}, 16'h1);
    check("busy_after_start", {15'h0, busy}, 16'h1);
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      tick();
      check("gap_in_ready", {15'h0, in_ready}, 16'h1);
      check("gap_no_valid", {15'h0, grad_valid}, 16'h0);
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_map4(input logic [15:0] d);
    for (int i = 0; i < 4; i++) begin
      send(d, 0);
      check("busy_during_map", {15'h0, busy}, 16'h1);
    end
    check("valid_after_last", {15'h0, grad_valid}, 16'h1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && grad_valid && grad_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_output: got %h expected no output", grad_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (grad_out !== e) begin
          n_errors++;
          $display("FAIL grad_out: got %h expected %h at %0t", grad_out, e, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'h0000;
    grad_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", {15'h0, in_ready}, 16'h0);
    check("rst_grad_valid", {15'h0, grad_valid}, 16'h0);
    check("rst_grad_out", grad_out, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {15'h0, in_ready}, 16'h0);

    // Map 1: four 1.0, in_valid held high -> 4.0
    exp_q.push_back(expv(16'h4400));
    do_start();
    send_map4(16'h3C00);
    tick();
    check("idle_after_hs_valid", {15'h0, grad_valid}, 16'h0);
    check("idle_after_hs_busy", {15'h0, busy}, 16'h0);

    // Map 2: 1, 2, -1, 0.5 with gaps 0/2/1 -> 2.5
    exp_q.push_back(expv(16'h4100));
    do_start();
    send(16'h3C00, 0);
    send(16'h4000, 0);
    send(16'hBC00, 2);
    send(16'h3800, 1);
    check("gap_map_valid", {15'h0, grad_valid}, 16'h1);
    tick();

    // Map 3: consumer stalls 5 cycles; extra in_valid and start ignored
    grad_ready = 1'b0;
    exp_q.push_back(expv(16'h4400));
    do_start();
    send_map4(16'h3C00);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h4000;
      start    = (k == 2);
      tick();
      check("stall_valid", {15'h0, grad_valid}, 16'h1);
      check("stall_in_ready", {15'h0, in_ready}, 16'h0);
      check("stall_grad_out", grad_out, expv(16'h4400));
    end
    in_valid   = 1'b0;
    start      = 1'b1;
    grad_ready = 1'b1;
    tick();
    start = 1'b0;
    check("hs_with_start_busy", {15'h0, busy}, 16'h0);
    check("hs_with_start_valid", {15'h0, grad_valid}, 16'h0);
    tick();
    check("start_ignored_in_done", {15'h0, busy}, 16'h0);

    // Map 4: reset after two elements, then a fresh map -> 4.0
    do_start();
    send(16'h4000, 0);
    send(16'h4000, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {15'h0, in_ready}, 16'h0);
    check("midrst_grad_valid", {15'h0, grad_valid}, 16'h0);
    check("midrst_grad_out", grad_out, 16'h0000);
    check("midrst_busy", {15'h0, busy}, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(expv(16'h4400));
    do_start();
    send_map4(16'h3C00);
    tick();

    // Maps 5/6: back-to-back, start the cycle after the handshake
    exp_q.push_back(expv(16'h4400));
    do_start();
    send_map4(16'h3C00);
    tick();
    check("b2b_idle", {15'h0, busy}, 16'h0);
    exp_q.push_back(expv(16'h4800));
    do_start();
    send_map4(16'h4000);
    tick();

    // Drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
